// File: rtl/vend_dispense_ctrl.sv
// Vend controller: validates a selection against price and stock, releases the item,
// returns change over valid/ready, then clears the upstream credit accumulator.
module vend_dispense_ctrl #(
  parameter int CURRENCY_WIDTH = 7,
  parameter int NUM_ITEMS      = 4,
  parameter int STOCK_WIDTH    = 4,
  parameter int STOCK_INIT     = 5,
  parameter int PRICE_0        = 15,
  parameter int PRICE_1        = 25,
  parameter int PRICE_2        = 40,
  parameter int PRICE_3        = 65
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CURRENCY_WIDTH-1:0] total_currency,
  input  logic                      currency_avail,
  input  logic [1:0]                item_sel,
  input  logic                      item_sel_valid,
  input  logic                      cancel,
  input  logic                      restock_valid,
  input  logic [1:0]                restock_sel,
  output logic                      dispense_valid,
  output logic                      item_dispense_valid,
  output logic [1:0]                item_dispense_id,
  output logic [CURRENCY_WIDTH-1:0] change_value,
  output logic                      change_valid,
  input  logic                      change_ready,
  output logic                      busy,
  output logic                      err_sold_out,
  output logic                      err_insufficient
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DISPENSE, S_CHANGE, S_REFUND, S_CLEAR, S_DRAIN
  } state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  sel_q, sel_d;
  logic [CURRENCY_WIDTH-1:0]   snap_q, snap_d;
  logic [CURRENCY_WIDTH-1:0]   change_value_q, change_value_d;
  logic [STOCK_WIDTH-1:0]      stock_q [NUM_ITEMS];
  logic                        err_so_d, err_ins_d, dec_en;
  logic                        busy_q, change_valid_q, dispense_valid_q;
  logic                        item_dispense_valid_q, err_so_q, err_ins_q;
  logic [1:0]                  item_dispense_id_q;

  function automatic logic [CURRENCY_WIDTH-1:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return CURRENCY_WIDTH'(PRICE_0);
      2'd1:    return CURRENCY_WIDTH'(PRICE_1);
      2'd2:    return CURRENCY_WIDTH'(PRICE_2);
      default: return CURRENCY_WIDTH'(PRICE_3);
    endcase
  endfunction

  // Saturates at zero so a misbehaving accumulator can never produce wrapped change.
  function automatic logic [CURRENCY_WIDTH-1:0] change_of(
    input logic [CURRENCY_WIDTH-1:0] credit, input logic [1:0] idx);
    if (credit < price_of(idx)) return '0;
    return credit - price_of(idx);
  endfunction

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    snap_d         = snap_q;
    change_value_d = change_value_q;
    err_so_d       = 1'b0;
    err_ins_d      = 1'b0;
    dec_en         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cancel && currency_avail) begin
          change_value_d = total_currency;
          state_d        = S_REFUND;
        end else if (item_sel_valid && currency_avail) begin
          sel_d   = item_sel;
          snap_d  = total_currency;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (stock_q[sel_q] == '0) begin
          err_so_d = 1'b1;
          state_d  = S_IDLE;
        end else if (snap_q < price_of(sel_q)) begin
          err_ins_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        dec_en         = 1'b1;
        change_value_d = change_of(total_currency, sel_q);
        state_d        = (change_value_d == '0) ? S_CLEAR : S_CHANGE;
      end
      S_CHANGE, S_REFUND: begin
        if (change_ready) begin
          change_value_d = '0;
          state_d        = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_DRAIN;
      // Hold until the accumulator has actually emptied so stale credit cannot re-vend.
      S_DRAIN: if (!currency_avail) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q               <= S_IDLE;
      change_value_q        <= '0;
      busy_q                <= 1'b0;
      change_valid_q        <= 1'b0;
      dispense_valid_q      <= 1'b0;
      item_dispense_valid_q <= 1'b0;
      item_dispense_id_q    <= 2'd0;
      err_so_q              <= 1'b0;
      err_ins_q             <= 1'b0;
    end else begin
      state_q               <= state_d;
      change_value_q        <= change_value_d;
      busy_q                <= (state_d != S_IDLE);
      change_valid_q        <= (state_d == S_CHANGE) || (state_d == S_REFUND);
      dispense_valid_q      <= (state_d == S_CLEAR);
      item_dispense_valid_q <= (state_d == S_DISPENSE);
      item_dispense_id_q    <= (state_d == S_DISPENSE) ? sel_q : 2'd0;
      err_so_q              <= err_so_d;
      err_ins_q             <= err_ins_d;
    end
  end

  always_ff @(posedge clk) begin
    sel_q  <= sel_d;
    snap_q <= snap_d;
  end

  // Restock takes priority over a same-cycle dispense decrement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_WIDTH'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (restock_valid && (restock_sel == i[1:0]))
          stock_q[i] <= STOCK_WIDTH'(STOCK_INIT);
        else if (dec_en && (sel_q == i[1:0]))
          stock_q[i] <= stock_q[i] - 1'b1;
      end
    end
  end

  assign dispense_valid      = dispense_valid_q;
  assign item_dispense_valid = item_dispense_valid_q;
  assign item_dispense_id    = item_dispense_id_q;
  assign change_value        = change_value_q;
  assign change_valid        = change_valid_q;
  assign busy                = busy_q;
  assign err_sold_out        = err_so_q;
  assign err_insufficient    = err_ins_q;

endmodule
